// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the pipelined immediate generator.
// The opcode table is used only when IMM_GEN_AUTODECODE_EN is defined.
package imm_gen_pkg;

  typedef logic [2:0] fmt_t;

  localparam fmt_t FMT_I   = 3'b000;
  localparam fmt_t FMT_S   = 3'b001;
  localparam fmt_t FMT_B   = 3'b010;
  localparam fmt_t FMT_U   = 3'b011;
  localparam fmt_t FMT_J   = 3'b100;
  localparam fmt_t FMT_ILL = 3'b111;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Encoded as {skid_valid, out_valid}; 2'b10 cannot be reached.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } buf_state_e;

  function automatic fmt_t opcode_to_fmt(input logic [6:0] opc);
    fmt_t f;
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: f = FMT_I;
      OPC_STORE:                                  f = FMT_S;
      OPC_BRANCH:                                 f = FMT_B;
      OPC_LUI, OPC_AUIPC:                         f = FMT_U;
      OPC_JAL:                                    f = FMT_J;
      default:                                    f = FMT_ILL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_gen_core.sv
// Combinational RV32 immediate extraction for formats I/S/B/U/J, sign-extended
// to XLEN. Unknown format codes yield zero and raise illegal.
module imm_gen_core
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  fmt_t            fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0] imm32;

  // NOTE: combinational logic uses blocking assignments and sets every output
  // to a default first, so no path through the case can infer a latch.
  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: illegal = 1'b1;
    endcase
  end

  // Bit 31 of every legal format is instr[31], so widening by sign is exact.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake and 2-entry skid
// buffer. Define IMM_GEN_AUTODECODE_EN to derive the format from the opcode.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_count
);

  fmt_t            fmt;
  logic [XLEN-1:0] core_imm;
  logic            core_illegal;

`ifdef IMM_GEN_AUTODECODE_EN
  logic unused_imm_src;
  assign unused_imm_src = ^imm_src;
  assign fmt            = opcode_to_fmt(instr[6:0]);
`else
  assign fmt = fmt_t'(imm_src);
`endif

  imm_gen_core #(.XLEN(XLEN)) u_core (
    .instr   (instr),
    .fmt     (fmt),
    .imm     (core_imm),
    .illegal (core_illegal)
  );

  buf_state_e       state_q, state_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d, skid_tag_q, skid_tag_d;
  logic             out_ill_q, out_ill_d, skid_ill_q, skid_ill_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             in_xfer, out_xfer;

  assign in_ready    = !state_q[1] && !rst;
  assign out_valid   = state_q[0];
  assign imm_ext     = out_imm_q;
  assign out_tag     = out_tag_q;
  assign out_illegal = out_ill_q;
  assign err_count   = err_cnt_q;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    out_imm_d  = out_imm_q;
    out_tag_d  = out_tag_q;
    out_ill_d  = out_ill_q;
    skid_imm_d = skid_imm_q;
    skid_tag_d = skid_tag_q;
    skid_ill_d = skid_ill_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          out_imm_d = core_imm;
          out_tag_d = in_tag;
          out_ill_d = core_illegal;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          out_imm_d = core_imm;
          out_tag_d = in_tag;
          out_ill_d = core_illegal;
        end else if (in_xfer) begin
          skid_imm_d = core_imm;
          skid_tag_d = in_tag;
          skid_ill_d = core_illegal;
          state_d    = ST_FULL;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain path exists.
        if (out_xfer) begin
          out_imm_d = skid_imm_q;
          out_tag_d = skid_tag_q;
          out_ill_d = skid_ill_q;
          state_d   = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (in_xfer && core_illegal && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // NOTE: state is written with non-blocking assignments so every flop samples
  // the pre-edge value. The payload registers are reset too: the visible output
  // must read zero during reset, and the skid copy is cheap enough to match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      out_imm_q  <= '0;
      out_tag_q  <= '0;
      out_ill_q  <= 1'b0;
      skid_imm_q <= '0;
      skid_tag_q <= '0;
      skid_ill_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      out_imm_q  <= out_imm_d;
      out_tag_q  <= out_tag_d;
      out_ill_q  <= out_ill_d;
      skid_imm_q <= skid_imm_d;
      skid_tag_q <= skid_tag_d;
      skid_ill_q <= skid_ill_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit/CNT_W=8 and a 64-bit/CNT_W=2 instance share
// stimulus and are compared every cycle against a queue model, plus literals.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic [3:0]  in_tag;
  logic        out_ready;
  logic        err_clr;

  logic        in_ready_a, out_valid_a, ill_a;
  logic [31:0] imm_a;
  logic [3:0]  tag_a;
  logic [7:0]  err_a;

  logic        in_ready_b, out_valid_b, ill_b;
  logic [63:0] imm_b;
  logic [3:0]  tag_b;
  logic [1:0]  err_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(4), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
    .out_valid(out_valid_a), .out_ready(out_ready), .imm_ext(imm_a),
    .out_tag(tag_a), .out_illegal(ill_a), .err_clr(err_clr), .err_count(err_a)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(4), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
    .out_valid(out_valid_b), .out_ready(out_ready), .imm_ext(imm_b),
    .out_tag(tag_b), .out_illegal(ill_b), .err_clr(err_clr), .err_count(err_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int model_fmt(input logic [31:0] w, input logic [2:0] src);
`ifdef IMM_GEN_AUTODECODE_EN
    case (w[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: return 0;
      7'h23:                      return 1;
      7'h63:                      return 2;
      7'h37, 7'h17:               return 3;
      7'h6F:                      return 4;
      default:                    return -1;
    endcase
`else
    return (src <= 3'd4) ? int'(src) : -1;
`endif
  endfunction

  // Arithmetic-shift formulation of the immediate, 64-bit wide.
  function automatic logic [63:0] ref_imm(input logic [31:0] w, input int f);
    longint s;
    s = longint'($signed(w));
    case (f)
      0: return s >>> 20;
      1: return ((s >>> 25) << 5) | longint'(w[11:7]);
      2: return ((s >>> 31) << 12) | (longint'(w[7]) << 11) |
                (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
      3: return (s >>> 12) << 12;
      4: return ((s >>> 31) << 20) | (longint'(w[19:12]) << 12) |
                (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
      default: return 64'd0;
    endcase
  endfunction

  typedef struct {
    logic [63:0] imm;
    logic [3:0]  tag;
    logic        ill;
  } ent_t;

  ent_t mq[$];
  int   cnt_a, cnt_b;
  bit   m_in_x, m_out_x;
  ent_t m_ent;
  int   m_f;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      cnt_a = 0;
      cnt_b = 0;
    end else begin
      m_in_x  = in_valid && (mq.size() < 2);
      m_out_x = (mq.size() > 0) && out_ready;
      m_f     = model_fmt(instr, imm_src);
      if (m_out_x) void'(mq.pop_front());
      if (m_in_x) begin
        m_ent.imm = ref_imm(instr, m_f);
        m_ent.tag = in_tag;
        m_ent.ill = (m_f < 0);
        mq.push_back(m_ent);
      end
      if (err_clr) begin
        cnt_a = 0;
        cnt_b = 0;
      end else if (m_in_x && m_f < 0) begin
        if (cnt_a < 255) cnt_a++;
        if (cnt_b < 3) cnt_b++;
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready_a", in_ready_a, !rst && mq.size() < 2);
    check("in_ready_b", in_ready_b, !rst && mq.size() < 2);
    check("out_valid_a", out_valid_a, mq.size() > 0);
    check("out_valid_b", out_valid_b, mq.size() > 0);
    check("err_a", err_a, cnt_a);
    check("err_b", err_b, cnt_b);
    if (mq.size() > 0) begin
      check("imm_a", imm_a, {32'd0, mq[0].imm[31:0]});
      check("imm_b", imm_b, mq[0].imm);
      check("tag_a", tag_a, mq[0].tag);
      check("tag_b", tag_b, mq[0].tag);
      check("ill_a", ill_a, mq[0].ill);
      check("ill_b", ill_b, mq[0].ill);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w, input logic [2:0] src, input logic [3:0] tag);
    in_valid = 1'b1;
    instr    = w;
    imm_src  = src;
    in_tag   = tag;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = '0; imm_src = '0; in_tag = '0;
    out_ready = 1'b1; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid_a, 0);
    check("rst_in_ready", in_ready_a, 0);
    check("rst_imm", imm_b, 0);
    check("rst_err", err_a, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready_a, 1);
    tick();

    // back-to-back, one cycle latency
    push(32'hFFF00093, 3'b000, 4'd1);
    check("t1_I_a", imm_a, 64'hFFFFFFFF);
    check("t1_I_b", imm_b, 64'hFFFFFFFFFFFFFFFF);
    check("t1_valid", out_valid_a, 1);
    push(32'hFE512E23, 3'b001, 4'd2);
    check("t1_S", imm_a, 64'hFFFFFFFC);
    push(32'hFE000CE3, 3'b010, 4'd3);
    check("t1_B", imm_a, 64'hFFFFFFF8);
    push(32'h123450B7, 3'b011, 4'd4);
    check("t1_U", imm_a, 64'h12345000);
    push(32'h001000EF, 3'b100, 4'd5);
    check("t1_J", imm_a, 64'h00000800);
    push(32'h800000B7, 3'b011, 4'd6);
    check("t2_U_a", imm_a, 64'h80000000);
    check("t2_U_b", imm_b, 64'hFFFFFFFF80000000);
    in_valid = 1'b0;
    tick();
    check("t1_drained", out_valid_a, 0);

    // backpressure
    out_ready = 1'b0;
    push(32'h00100093, 3'b000, 4'd1);
    check("bp_tag1", tag_a, 1);
    check("bp_ready1", in_ready_a, 1);
    push(32'h00200093, 3'b000, 4'd2);
    check("bp_ready_full", in_ready_a, 0);
    check("bp_hold1", tag_a, 1);
    push(32'h00300093, 3'b000, 4'd3);
    check("bp_still_full", in_ready_b, 0);
    check("bp_hold_imm", imm_a, 64'd1);
    out_ready = 1'b1;
    tick();
    check("bp_tag2", tag_a, 2);
    check("bp_ready_again", in_ready_a, 1);
    tick();
    check("bp_tag3", tag_b, 3);
    in_valid = 1'b0;
    tick();
    check("bp_empty", out_valid_b, 0);

    // illegal format and saturating counter
    push(32'hFFFFFFFF, 3'b111, 4'd4);
    check("ill_imm", imm_a, 0);
    check("ill_flag", ill_a, 1);
    check("ill_cnt", err_a, 1);
    repeat (5) tick();
    check("ill_cnt6_a", err_a, 6);
    check("ill_sat_b", err_b, 3);
    err_clr = 1'b1;
    tick();
    check("clr_prio_a", err_a, 0);
    check("clr_prio_b", err_b, 0);
    err_clr = 1'b0;
    in_valid = 1'b0;
    tick();

    // reset while full
    out_ready = 1'b0;
    push(32'hFFFFFFFF, 3'b111, 4'd5);
    push(32'h00200093, 3'b000, 4'd6);
    in_valid = 1'b0;
    check("pre_rst_full", in_ready_a, 0);
    check("pre_rst_err", err_a, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid_a", out_valid_a, 0);
    check("arst_valid_b", out_valid_b, 0);
    check("arst_err", err_a, 0);
    check("arst_in_ready", in_ready_a, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rerun_in_ready", in_ready_a, 1);
    out_ready = 1'b1;
    push(32'h00300093, 3'b000, 4'd9);
    check("rerun_tag", tag_a, 9);
    check("rerun_imm", imm_a, 64'd3);

    // format source: opcode in autodecode builds, imm_src otherwise
`ifdef IMM_GEN_AUTODECODE_EN
    push(32'hFE000CE3, 3'b111, 4'd10);
`else
    push(32'hFE000CE3, 3'b010, 4'd10);
`endif
    check("fmt_B_imm", imm_a, 64'hFFFFFFF8);
    check("fmt_B_legal", ill_a, 0);
`ifdef IMM_GEN_AUTODECODE_EN
    push(32'h00000000, 3'b111, 4'd11);
`else
    push(32'h00000093, 3'b101, 4'd11);
`endif
    check("fmt_ill", ill_a, 1);
    check("fmt_ill_imm", imm_b, 0);
    in_valid = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
